updown_pulse_gen: RTL



---
 rtl/updown_pulse_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/updown_pulse_gen.sv
// Two-button front end: per-button synchroniser, debouncer and press/hold/repeat
// FSM, producing mutually exclusive single-cycle increment/decrement pulses.
module updown_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic repeat_en,
  output logic increment,
  output logic decrement,
  output logic up_level,
  output logic down_level
);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Channel 0 is up, channel 1 is down.
  logic [1:0] btn;
  logic [1:0] level;
  logic [1:0] ev;

  assign btn = {btn_down, btn_up};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      logic             sync1_reg;
      logic             sync2_reg;
      logic             level_reg;
      logic [CNT_W-1:0] db_cnt_reg;
      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] tmr_reg;
      logic [CNT_W-1:0] tmr_next;
      logic             ev_next;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= btn[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Any cycle where the synced value agrees with the level restarts the count.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          level_reg  <= 1'b0;
          db_cnt_reg <= '0;
        end else if (sync2_reg == level_reg) begin
          db_cnt_reg <= '0;
        end else if (db_cnt_reg == DB_LAST) begin
          level_reg  <= ~level_reg;
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + CNT_ONE;
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_reg <= IDLE;
          tmr_reg   <= '0;
        end else begin
          state_reg <= state_next;
          tmr_reg   <= tmr_next;
        end
      end

      always_comb begin
        state_next = state_reg;
        tmr_next   = tmr_reg + CNT_ONE;
        ev_next    = 1'b0;
        case (state_reg)
          IDLE: begin
            tmr_next = '0;
            if (level_reg) begin
              ev_next    = 1'b1;
              state_next = HOLD;
            end
          end
          HOLD: begin
            if (!level_reg) begin
              state_next = IDLE;
              tmr_next   = '0;
            end else if (!repeat_en) begin
              tmr_next = '0;
            end else if (tmr_reg == HOLD_LAST) begin
              ev_next    = 1'b1;
              state_next = REPEAT;
              tmr_next   = '0;
            end
          end
          REPEAT: begin
            if (!level_reg) begin
              state_next = IDLE;
              tmr_next   = '0;
            end else if (!repeat_en) begin
              state_next = HOLD;
              tmr_next   = '0;
            end else if (tmr_reg == REP_LAST) begin
              ev_next  = 1'b1;
              tmr_next = '0;
            end
          end
          default: begin
            state_next = IDLE;
            tmr_next   = '0;
          end
        endcase
      end

      assign level[gi] = level_reg;
      assign ev[gi]    = ev_next;
    end
  endgenerate

  // A held level on either side locks out the other channel's events.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      increment <= 1'b0;
      decrement <= 1'b0;
    end else begin
      increment <= ev[0] & ~ev[1] & ~level[1];
      decrement <= ev[1] & ~ev[0] & ~level[0];
    end
  end

  assign up_level   = level[0];
  assign down_level = level[1];

endmodule
